// File: rtl/mac_array_ctrl_pkg.sv
// Shared definitions for the MAC array sequencer: register map, control/status bit
// positions and FSM state encoding.
package mac_array_ctrl_pkg;

    localparam logic [2:0] AddrCtrl   = 3'd0;
    localparam logic [2:0] AddrStatus = 3'd1;
    localparam logic [2:0] AddrXPush  = 3'd2;
    localparam logic [2:0] AddrBias   = 3'd3;
    localparam logic [2:0] AddrLen    = 3'd4;
    localparam logic [2:0] AddrResPop = 3'd5;
    localparam logic [2:0] AddrResCnt = 3'd6;
    localparam logic [2:0] AddrCycles = 3'd7;

    localparam int unsigned CtrlLoadw = 0;
    localparam int unsigned CtrlStart = 1;
    localparam int unsigned CtrlClear = 2;

    localparam int unsigned StBusy     = 0;
    localparam int unsigned StXFull    = 1;
    localparam int unsigned StXEmpty   = 2;
    localparam int unsigned StResFull  = 3;
    localparam int unsigned StResEmpty = 4;
    localparam int unsigned StDone     = 5;
    localparam int unsigned StUnf      = 6;
    localparam int unsigned StOvf      = 7;

    typedef enum logic [2:0] {
        StIdle,
        StLoadw,
        StStream,
        StDrain,
        StFinish
    } state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mac_array_ctrl_if.sv
// Register bus plus PE-row stream for the MAC array sequencer.
// The sequencer takes the slave side; host and PE row together form the master side.
interface mac_array_ctrl_if #(
    parameter int unsigned N_PE = 4,
    parameter int unsigned XW   = 8,
    parameter int unsigned YW   = 32
);
    logic [2:0]           reg_addr;
    logic                 reg_read;
    logic                 reg_write;
    logic [31:0]          reg_writedata;
    logic [31:0]          reg_readdata;
    logic                 reg_readdatavalid;
    logic                 load_weight;
    logic                 valid_in;
    logic [N_PE*XW-1:0]   x_in;
    logic [YW-1:0]        y_in;
    logic [YW-1:0]        y_out;
    logic                 valid_out;

    modport slave (
        input  reg_addr, reg_read, reg_write, reg_writedata, y_out, valid_out,
        output reg_readdata, reg_readdatavalid, load_weight, valid_in, x_in, y_in
    );

    modport master (
        output reg_addr, reg_read, reg_write, reg_writedata, y_out, valid_out,
        input  reg_readdata, reg_readdatavalid, load_weight, valid_in, x_in, y_in
    );

endinterface

// File: rtl/mac_array_ctrl_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; a pop on empty is ignored.
module mac_array_ctrl_sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_flush,
    input  logic                      i_push,
    input  logic [W-1:0]              i_wdata,
    input  logic                      i_pop,
    output logic [W-1:0]              o_rdata,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FullCnt) || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_count == FullCnt);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/mac_array_ctrl.sv
// Register-mapped sequencer feeding a MAC PE row: streams queued x vectors into the row
// under result-FIFO credit and collects the row results for the host to pop.
module mac_array_ctrl
    import mac_array_ctrl_pkg::*;
#(
    parameter int unsigned N_PE  = 4,
    parameter int unsigned XW    = 8,
    parameter int unsigned YW    = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mac_array_ctrl_if.slave io_bus
);

    localparam int unsigned XBits = N_PE * XW;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    state_e             r_state;
    logic [15:0]        r_len;
    logic [15:0]        r_len_lat;
    logic [15:0]        r_issued;
    logic [15:0]        r_received;
    logic [YW-1:0]      r_bias;
    logic [YW-1:0]      r_bias_lat;
    logic [31:0]        r_cycles;
    logic               r_done;
    logic               r_ovf;
    logic               r_unf;
    logic               r_load_weight;
    logic               r_valid_in;
    logic [XBits-1:0]   r_x_in;
    logic [YW-1:0]      r_y_in;
    logic [31:0]        r_readdata;
    logic               r_readdatavalid;

    logic               w_wr_ctrl;
    logic               w_wr_xpush;
    logic               w_wr_bias;
    logic               w_wr_len;
    logic               w_rd_pop;
    logic               w_clear;
    logic               w_loadw;
    logic               w_start;
    logic               w_busy;
    logic               w_issue;
    logic               w_credit;
    logic [15:0]        w_inflight;
    logic               w_x_pop;
    logic               w_res_pop;
    logic [XBits-1:0]   w_x_rdata;
    logic               w_x_full;
    logic               w_x_empty;
    logic [CW-1:0]      w_x_count;
    logic [YW-1:0]      w_res_rdata;
    logic               w_res_full;
    logic               w_res_empty;
    logic [CW-1:0]      w_res_count;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_wr_ctrl  = io_bus.reg_write && (io_bus.reg_addr == AddrCtrl);
    assign w_wr_xpush = io_bus.reg_write && (io_bus.reg_addr == AddrXPush);
    assign w_wr_bias  = io_bus.reg_write && (io_bus.reg_addr == AddrBias);
    assign w_wr_len   = io_bus.reg_write && (io_bus.reg_addr == AddrLen);
    assign w_rd_pop   = io_bus.reg_read && (io_bus.reg_addr == AddrResPop);

    // CLEAR overrides everything; LOADW overrides START in the same write.
    assign w_clear = w_wr_ctrl && io_bus.reg_writedata[CtrlClear];
    assign w_loadw = w_wr_ctrl && io_bus.reg_writedata[CtrlLoadw] && !w_clear;
    assign w_start = w_wr_ctrl && io_bus.reg_writedata[CtrlStart] &&
                     !io_bus.reg_writedata[CtrlLoadw] && !w_clear;

    assign w_busy = (r_state == StLoadw) || (r_state == StStream) || (r_state == StDrain);

    // Results outstanding in the row plus results parked in the FIFO never exceed DEPTH.
    assign w_inflight = r_issued - r_received;
    assign w_credit   = (32'(w_inflight) + 32'(w_res_count)) < DEPTH;
    assign w_issue    = (r_state == StStream) && !w_x_empty && w_credit &&
                        (r_issued != r_len_lat) && !w_clear;

    assign w_x_pop   = w_issue || ((r_state == StIdle) && w_loadw && !w_x_empty);
    assign w_res_pop = w_rd_pop && !w_res_empty;
    assign w_unused  = ^w_x_count;

    mac_array_ctrl_sync_fifo #(
        .W     (XBits),
        .DEPTH (DEPTH)
    ) u_x_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_clear),
        .i_push  (w_wr_xpush),
        .i_wdata (io_bus.reg_writedata[XBits-1:0]),
        .i_pop   (w_x_pop),
        .o_rdata (w_x_rdata),
        .o_full  (w_x_full),
        .o_empty (w_x_empty),
        .o_count (w_x_count)
    );

    mac_array_ctrl_sync_fifo #(
        .W     (YW),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_clear),
        .i_push  (io_bus.valid_out),
        .i_wdata (io_bus.y_out),
        .i_pop   (w_res_pop),
        .o_rdata (w_res_rdata),
        .o_full  (w_res_full),
        .o_empty (w_res_empty),
        .o_count (w_res_count)
    );

    always_comb begin
        w_rdata = '0;
        case (io_bus.reg_addr)
            AddrStatus: w_rdata = {24'd0, r_ovf, r_unf, r_done, w_res_empty, w_res_full,
                                   w_x_empty, w_x_full, w_busy};
            AddrBias:   w_rdata = 32'($signed(r_bias));
            AddrLen:    w_rdata = {16'd0, r_len};
            AddrResPop: w_rdata = w_res_empty ? 32'd0 : 32'($signed(w_res_rdata));
            AddrResCnt: w_rdata = 32'(w_res_count);
            AddrCycles: w_rdata = r_cycles;
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
            r_len           <= '0;
            r_bias          <= '0;
            r_ovf           <= 1'b0;
            r_unf           <= 1'b0;
        end else begin
            r_readdatavalid <= io_bus.reg_read;
            if (io_bus.reg_read) begin
                r_readdata <= w_rdata;
            end
            if (w_wr_len) begin
                r_len <= io_bus.reg_writedata[15:0];
            end
            if (w_wr_bias) begin
                r_bias <= io_bus.reg_writedata[YW-1:0];
            end
            if (w_clear) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else begin
                if (w_wr_xpush && w_x_full && !w_x_pop) begin
                    r_ovf <= 1'b1;
                end
                if (w_rd_pop && w_res_empty) begin
                    r_unf <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_len_lat     <= '0;
            r_bias_lat    <= '0;
            r_issued      <= '0;
            r_received    <= '0;
            r_cycles      <= '0;
            r_done        <= 1'b0;
            r_load_weight <= 1'b0;
            r_valid_in    <= 1'b0;
            r_x_in        <= '0;
            r_y_in        <= '0;
        end else if (w_clear) begin
            r_state       <= StIdle;
            r_issued      <= '0;
            r_received    <= '0;
            r_cycles      <= '0;
            r_done        <= 1'b0;
            r_load_weight <= 1'b0;
            r_valid_in    <= 1'b0;
            r_x_in        <= '0;
            r_y_in        <= '0;
        end else begin
            r_load_weight <= 1'b0;
            r_valid_in    <= 1'b0;
            if (w_busy && io_bus.valid_out) begin
                r_received <= r_received + 16'd1;
            end
            case (r_state)
                StIdle: begin
                    if (w_loadw && !w_x_empty) begin
                        r_state       <= StLoadw;
                        r_load_weight <= 1'b1;
                        r_x_in        <= w_x_rdata;
                    end else if (w_start) begin
                        r_len_lat  <= r_len;
                        r_bias_lat <= r_bias;
                        r_issued   <= '0;
                        r_received <= '0;
                        r_cycles   <= '0;
                        r_state    <= (r_len != 16'd0) ? StStream : StFinish;
                    end
                end
                StLoadw: begin
                    r_state <= StIdle;
                end
                StStream: begin
                    r_cycles <= sat_inc32(r_cycles);
                    if (w_issue) begin
                        r_valid_in <= 1'b1;
                        r_x_in     <= w_x_rdata;
                        r_y_in     <= r_bias_lat;
                        r_issued   <= r_issued + 16'd1;
                        if (r_issued + 16'd1 == r_len_lat) begin
                            r_state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    r_cycles <= sat_inc32(r_cycles);
                    if (r_received == r_len_lat) begin
                        r_state <= StFinish;
                    end
                end
                StFinish: begin
                    r_done  <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.reg_readdata      = r_readdata;
    assign io_bus.reg_readdatavalid = r_readdatavalid;
    assign io_bus.load_weight       = r_load_weight;
    assign io_bus.valid_in          = r_valid_in;
    assign io_bus.x_in              = r_x_in;
    assign io_bus.y_in              = r_y_in;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: host register traffic plus a 2-cycle PE row model;
// expected results come from a dot-product reference over the pushed vectors.
module tb_mac_array_ctrl;

    localparam int unsigned N_PE  = 4;
    localparam int unsigned XW    = 8;
    localparam int unsigned YW    = 32;
    localparam int unsigned DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mac_array_ctrl_if #(.N_PE(N_PE), .XW(XW), .YW(YW)) bus ();

    mac_array_ctrl #(
        .N_PE  (N_PE),
        .XW    (XW),
        .YW    (YW),
        .DEPTH (DEPTH)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          vin_cnt  = 0;
    int          lw_cnt   = 0;
    logic [31:0] lw_x     = '0;
    logic [31:0] pe_w     = '0;
    logic [31:0] model_w  = '0;
    logic        p1_v;
    logic [31:0] p1_y;
    logic [31:0] exp_q[$];

    // y = bias + sum over lanes of signed x * signed w
    function automatic logic [31:0] pe_calc(input logic [31:0] b, input logic [31:0] x,
                                            input logic [31:0] w);
        int  acc;
        byte xb;
        byte wb;
        acc = int'($signed(b));
        for (int i = 0; i < 4; i++) begin
            xb  = x[8*i +: 8];
            wb  = w[8*i +: 8];
            acc = acc + int'(xb) * int'(wb);
        end
        return acc;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_v          <= 1'b0;
            p1_y          <= '0;
            bus.valid_out <= 1'b0;
            bus.y_out     <= '0;
        end else begin
            p1_v          <= bus.valid_in;
            p1_y          <= pe_calc(bus.y_in, bus.x_in, pe_w);
            bus.valid_out <= p1_v;
            bus.y_out     <= p1_y;
            if (bus.load_weight) pe_w <= bus.x_in;
        end
    end

    always @(posedge clk) begin
        if (bus.valid_in) vin_cnt <= vin_cnt + 1;
        if (bus.load_weight) begin
            lw_cnt <= lw_cnt + 1;
            lw_x   <= bus.x_in;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.reg_write     = 1'b1;
        bus.reg_addr      = a;
        bus.reg_writedata = d;
        @(negedge clk);
        bus.reg_write     = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.reg_read = 1'b1;
        bus.reg_addr = a;
        @(negedge clk);
        bus.reg_read = 1'b0;
        d = bus.reg_readdata;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        logic [31:0] s;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            reg_rd(3'd1, s);
            ok = s[5];
        end
    endtask

    task automatic do_clear();
        reg_wr(3'd0, 32'h4);
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [98:0] outs;
        logic [31:0] d;
        rst_n = 1'b0;
        idle(2);
        outs = {bus.load_weight, bus.valid_in, bus.reg_readdatavalid, bus.x_in, bus.y_in,
                bus.reg_readdata};
        n_checks++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus.reg_read = 1'b1;
        bus.reg_addr = 3'd1;
        @(negedge clk);
        bus.reg_read = 1'b0;
        n_checks++;
        if (bus.reg_readdatavalid !== 1'b1 || bus.reg_readdata !== 32'h14) begin
            n_fail++; $display("FAIL reset_status: got rdv=%b data=%h expected rdv=1 data=00000014",
                               bus.reg_readdatavalid, bus.reg_readdata);
        end
        @(negedge clk);
        n_checks++;
        if (bus.reg_readdatavalid !== 1'b0) begin
            n_fail++; $display("FAIL rdv_one_cycle: got %b expected 0", bus.reg_readdatavalid);
        end
        reg_rd(3'd4, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_len: got %h expected 0", d); end
        reg_rd(3'd3, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_bias: got %h expected 0", d); end
        reg_rd(3'd7, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_cycles: got %h expected 0", d); end
    endtask

    task automatic test_loadw();
        logic [31:0] d;
        int          l0;
        reg_wr(3'd2, 32'h0403_0201);
        l0 = lw_cnt;
        reg_wr(3'd0, 32'h1);
        idle(3);
        model_w = 32'h0403_0201;
        n_checks++;
        if (lw_cnt - l0 != 1 || lw_x !== 32'h0403_0201) begin
            n_fail++; $display("FAIL loadw_pulse: got %0d cycles x=%h expected 1 cycle x=04030201",
                               lw_cnt - l0, lw_x);
        end
        reg_rd(3'd1, d);
        n_checks++;
        if ((d & 32'h7) !== 32'h4) begin
            n_fail++; $display("FAIL loadw_x_empty: got status %h expected low bits 4", d);
        end
        reg_wr(3'd0, 32'h3);
        idle(3);
        n_checks++;
        if (lw_cnt - l0 != 1) begin
            n_fail++; $display("FAIL loadw_empty_ignored: got %0d pulses expected 1", lw_cnt - l0);
        end
    endtask

    task automatic test_stream();
        logic [31:0] d, x, e;
        bit          ok;
        int          v0;
        do_clear();
        reg_wr(3'd3, 32'd5);
        reg_wr(3'd4, 32'd3);
        for (int i = 0; i < 3; i++) begin
            x = $urandom();
            reg_wr(3'd2, x);
            exp_q.push_back(pe_calc(32'd5, x, model_w));
        end
        v0 = vin_cnt;
        reg_wr(3'd0, 32'h2);
        wait_done(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stream_done: got 0 expected 1"); end
        n_checks++;
        if (vin_cnt - v0 != 3) begin
            n_fail++; $display("FAIL stream_vin: got %0d expected 3", vin_cnt - v0);
        end
        reg_rd(3'd6, d);
        n_checks++;
        if (d !== 32'd3) begin n_fail++; $display("FAIL stream_rescnt: got %0d expected 3", d); end
        reg_rd(3'd7, d);
        n_checks++;
        if (d == 32'd0) begin n_fail++; $display("FAIL stream_cycles: got 0 expected nonzero"); end
        for (int i = 0; i < 3; i++) begin
            reg_rd(3'd5, d);
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e) begin n_fail++; $display("FAIL stream_pop%0d: got %h expected %h", i, d, e); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] d, x, e, b;
        bit          ok;
        int          v0;
        do_clear();
        b = $urandom();
        reg_wr(3'd3, b);
        reg_wr(3'd4, 32'd4);
        v0 = vin_cnt;
        for (int i = 0; i < 2; i++) begin
            x = $urandom();
            reg_wr(3'd2, x);
            exp_q.push_back(pe_calc(b, x, model_w));
        end
        reg_wr(3'd0, 32'h2);
        idle(30);
        reg_rd(3'd1, d);
        n_checks++;
        if (vin_cnt - v0 != 2 || (d & 32'h21) !== 32'h01) begin
            n_fail++; $display("FAIL stall_hold: got vin=%0d status=%h expected vin=2 busy=1 done=0",
                               vin_cnt - v0, d);
        end
        for (int i = 0; i < 2; i++) begin
            x = $urandom();
            reg_wr(3'd2, x);
            exp_q.push_back(pe_calc(b, x, model_w));
        end
        wait_done(100, ok);
        n_checks++;
        if (!ok || vin_cnt - v0 != 4) begin
            n_fail++; $display("FAIL stall_resume: got done=%b vin=%0d expected done=1 vin=4",
                               ok, vin_cnt - v0);
        end
        for (int i = 0; i < 4; i++) begin
            reg_rd(3'd5, d);
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e) begin n_fail++; $display("FAIL stall_pop%0d: got %h expected %h", i, d, e); end
        end
    endtask

    task automatic test_credit();
        logic [31:0] d, x, e, b;
        bit          ok;
        int          v0;
        do_clear();
        b = $urandom_range(0, 1000);
        reg_wr(3'd3, b);
        reg_wr(3'd4, 32'd20);
        for (int i = 0; i < 16; i++) begin
            x = $urandom();
            reg_wr(3'd2, x);
            exp_q.push_back(pe_calc(b, x, model_w));
        end
        v0 = vin_cnt;
        reg_wr(3'd0, 32'h2);
        idle(60);
        for (int i = 0; i < 4; i++) begin
            x = $urandom();
            reg_wr(3'd2, x);
            exp_q.push_back(pe_calc(b, x, model_w));
        end
        idle(40);
        reg_rd(3'd1, d);
        n_checks++;
        if (vin_cnt - v0 != 16 || d[0] !== 1'b1) begin
            n_fail++; $display("FAIL credit_stall: got vin=%0d busy=%b expected vin=16 busy=1",
                               vin_cnt - v0, d[0]);
        end
        reg_rd(3'd6, d);
        n_checks++;
        if (d !== 32'd16) begin n_fail++; $display("FAIL credit_rescnt: got %0d expected 16", d); end
        for (int i = 0; i < 4; i++) begin
            reg_rd(3'd5, d);
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e) begin n_fail++; $display("FAIL credit_pop%0d: got %h expected %h", i, d, e); end
        end
        wait_done(100, ok);
        n_checks++;
        if (!ok || vin_cnt - v0 != 20) begin
            n_fail++; $display("FAIL credit_finish: got done=%b vin=%0d expected done=1 vin=20",
                               ok, vin_cnt - v0);
        end
        for (int i = 0; i < 16; i++) begin
            reg_rd(3'd5, d);
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e) begin n_fail++; $display("FAIL credit_tail%0d: got %h expected %h", i, d, e); end
        end
    endtask

    task automatic test_ovf_unf_clear();
        logic [31:0] d;
        bit          ok;
        do_clear();
        for (int i = 0; i < 17; i++) reg_wr(3'd2, $urandom());
        reg_rd(3'd1, d);
        n_checks++;
        if (d !== 32'h92) begin n_fail++; $display("FAIL ovf_status: got %h expected 00000092", d); end
        reg_rd(3'd5, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL unf_data: got %h expected 0", d); end
        reg_rd(3'd1, d);
        n_checks++;
        if (d !== 32'hD2) begin n_fail++; $display("FAIL unf_status: got %h expected 000000d2", d); end
        reg_wr(3'd4, 32'd16);
        reg_wr(3'd0, 32'h2);
        wait_done(100, ok);
        reg_rd(3'd6, d);
        n_checks++;
        if (!ok || d !== 32'd16) begin
            n_fail++; $display("FAIL ovf_kept16: got done=%b rescnt=%0d expected done=1 rescnt=16", ok, d);
        end
        do_clear();
        reg_rd(3'd1, d);
        n_checks++;
        if (d !== 32'h14) begin n_fail++; $display("FAIL clear_status: got %h expected 00000014", d); end
        reg_rd(3'd7, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL clear_cycles: got %h expected 0", d); end
    endtask

    task automatic test_len_zero();
        logic [31:0] d;
        int          v0;
        do_clear();
        reg_wr(3'd4, 32'd0);
        v0 = vin_cnt;
        reg_wr(3'd0, 32'h2);
        idle(2);
        reg_rd(3'd1, d);
        n_checks++;
        if (d !== 32'h34 || vin_cnt != v0) begin
            n_fail++; $display("FAIL len_zero: got status=%h vin=%0d expected status=00000034 vin=0",
                               d, vin_cnt - v0);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [98:0] outs;
        logic [31:0] d;
        bit          seen;
        do_clear();
        reg_wr(3'd3, 32'h1234);
        reg_wr(3'd4, 32'd8);
        for (int i = 0; i < 8; i++) reg_wr(3'd2, $urandom() | 32'h1);
        reg_wr(3'd0, 32'h2);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.valid_in) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL midrst_stream_start: got no valid_in expected one"); end
        rst_n = 1'b0;
        #1;
        outs = {bus.load_weight, bus.valid_in, bus.reg_readdatavalid, bus.x_in, bus.y_in,
                bus.reg_readdata};
        n_checks++;
        if (outs !== '0) begin n_fail++; $display("FAIL midrst_outputs: got %h expected 0", outs); end
        idle(3);
        rst_n = 1'b1;
        reg_rd(3'd1, d);
        n_checks++;
        if (d !== 32'h14) begin n_fail++; $display("FAIL midrst_status: got %h expected 00000014", d); end
    endtask

    initial begin
        bus.reg_addr      = '0;
        bus.reg_read      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_writedata = '0;
        #1 rst_n = 1'b0;
        test_reset();
        test_loadw();
        test_stream();
        test_stall();
        test_credit();
        test_ovf_unf_clear();
        test_len_zero();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
